// File: rtl/avg_threshold_detector.sv
// Hysteresis/dwell classifier for the moving-average stream.
// Tracks HIGH excursions, their peak and a saturating rise count.
module avg_threshold_detector #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 8,
  parameter int MIN_DWELL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] thr_hi,
  input  logic [DATA_W-1:0] thr_lo,
  input  logic              clear,
  output logic              above,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic [DATA_W-1:0] peak,
  output logic [CNT_W-1:0]  event_cnt,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    S_INIT,
    S_LOW,
    S_HIGH
  } state_t;

  localparam logic [3:0]       DW_MAX  = 4'(MIN_DWELL);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            r_state;
  logic [3:0]        r_dwell;
  logic [DATA_W-1:0] r_peak_run;
  logic [DATA_W-1:0] r_peak;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_above;
  logic              r_rise;
  logic              r_fall;
  logic              r_cfg_err;

  logic [3:0]        w_dwell_nxt;
  logic [DATA_W-1:0] w_run_max;
  logic              w_ge_hi;
  logic              w_le_lo;
  logic              w_eval;

  assign w_dwell_nxt = r_dwell + 4'd1;
  assign w_run_max   = (in_data > r_peak_run) ? in_data : r_peak_run;
  assign w_ge_hi     = in_data >= thr_hi;
  assign w_le_lo     = in_data <= thr_lo;
  assign w_eval      = in_valid && !r_cfg_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_INIT;
      r_dwell    <= '0;
      r_peak_run <= '0;
      r_peak     <= '0;
      r_cnt      <= '0;
      r_above    <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= thr_lo >= thr_hi;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      if (clear) begin
        r_state    <= S_INIT;
        r_dwell    <= '0;
        r_peak_run <= '0;
        r_peak     <= '0;
        r_cnt      <= '0;
        r_above    <= 1'b0;
      end else if (w_eval) begin
        unique case (r_state)
          S_INIT: begin
            if (w_ge_hi) begin
              r_state    <= S_HIGH;
              r_above    <= 1'b1;
              r_peak_run <= in_data;
            end else begin
              r_state <= S_LOW;
            end
          end
          S_LOW: begin
            if (!w_ge_hi) begin
              r_dwell <= '0;
            end else if (w_dwell_nxt >= DW_MAX) begin
              r_state    <= S_HIGH;
              r_above    <= 1'b1;
              r_dwell    <= '0;
              r_rise     <= 1'b1;
              r_peak_run <= in_data;
              if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
            end else begin
              r_dwell <= w_dwell_nxt;
            end
          end
          S_HIGH: begin
            r_peak_run <= w_run_max;
            if (!w_le_lo) begin
              r_dwell <= '0;
            end else if (w_dwell_nxt >= DW_MAX) begin
              r_state <= S_LOW;
              r_above <= 1'b0;
              r_dwell <= '0;
              r_fall  <= 1'b1;
              r_peak  <= w_run_max;
            end else begin
              r_dwell <= w_dwell_nxt;
            end
          end
          default: begin
            r_state <= S_INIT;
            r_above <= 1'b0;
            r_dwell <= '0;
          end
        endcase
      end
    end
  end

  assign above      = r_above;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign peak       = r_peak;
  assign event_cnt  = r_cnt;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_avg_threshold_detector.sv
// Scoreboard bench for avg_threshold_detector.
// Directed samples push expected outputs; a monitor pops and compares.
module tb_avg_threshold_detector;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] thr_hi;
  logic [7:0] thr_lo;
  logic       clear;
  logic       above;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] peak;
  logic [2:0] event_cnt;
  logic       cfg_err;

  typedef struct packed {
    logic       a;
    logic       r;
    logic       f;
    logic [2:0] c;
    logic [7:0] p;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_smp  = 0;

  avg_threshold_detector #(
    .DATA_W(8),
    .CNT_W(3),
    .MIN_DWELL(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .thr_hi(thr_hi),
    .thr_lo(thr_lo),
    .clear(clear),
    .above(above),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .peak(peak),
    .event_cnt(event_cnt),
    .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: one expected entry per accepted sample, pulses idle otherwise
  always @(posedge clk) begin
    logic v;
    logic rs;
    exp_t x;
    v  = in_valid;
    rs = rst_n;
    #1;
    if (rs) begin
      n_chk++;
      if (v) begin
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: got valid sample, expected no pending entry");
        end else begin
          x = q.pop_front();
          n_smp++;
          if (above !== x.a || rise_pulse !== x.r || fall_pulse !== x.f ||
              event_cnt !== x.c || peak !== x.p || cfg_err !== x.e) begin
            n_fail++;
            $display("FAIL sample%0d: got a=%0b r=%0b f=%0b cnt=%0d pk=%0d e=%0b, expected a=%0b r=%0b f=%0b cnt=%0d pk=%0d e=%0b",
                     n_smp, above, rise_pulse, fall_pulse, event_cnt, peak,
                     cfg_err, x.a, x.r, x.f, x.c, x.p, x.e);
          end
        end
      end else if (rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_pulse: got r=%0b f=%0b, expected r=0 f=0",
                 rise_pulse, fall_pulse);
      end
    end
  end

  task automatic smp(input logic [7:0] d, input logic a, input logic r,
                     input logic f, input logic [2:0] c, input logic [7:0] p,
                     input logic e);
    exp_t x;
    x = '{a: a, r: r, f: f, c: c, p: p, e: e};
    in_valid = 1'b1;
    in_data  = d;
    q.push_back(x);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    n_chk++;
    if ({above, rise_pulse, fall_pulse, peak, event_cnt, cfg_err} !== '0) begin
      n_fail++;
      $display("FAIL %s: got a=%0b r=%0b f=%0b pk=%0d cnt=%0d e=%0b, expected all 0",
               nm, above, rise_pulse, fall_pulse, peak, event_cnt, cfg_err);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'($urandom);
    in_data  = 8'($urandom);
    thr_hi   = 8'($urandom);
    thr_lo   = 8'($urandom);
    clear    = 1'($urandom);
    #7;
    chk_zero("reset_init");
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'd0;
    thr_hi   = 8'd100;
    thr_lo   = 8'd50;
    clear    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // basic excursion
    smp(8'd10,  0, 0, 0, 3'd0, 8'd0,   0);
    smp(8'd120, 0, 0, 0, 3'd0, 8'd0,   0);
    smp(8'd130, 1, 1, 0, 3'd1, 8'd0,   0);
    smp(8'd140, 1, 0, 0, 3'd1, 8'd0,   0);
    smp(8'd40,  1, 0, 0, 3'd1, 8'd0,   0);
    smp(8'd30,  0, 0, 1, 3'd1, 8'd140, 0);

    // chatter with idle gaps
    smp(8'd120, 0, 0, 0, 3'd1, 8'd140, 0); idle(2);
    smp(8'd90,  0, 0, 0, 3'd1, 8'd140, 0); idle(1);
    smp(8'd120, 0, 0, 0, 3'd1, 8'd140, 0); idle(3);
    smp(8'd90,  0, 0, 0, 3'd1, 8'd140, 0); idle(1);
    smp(8'd120, 0, 0, 0, 3'd1, 8'd140, 0); idle(2);
    smp(8'd120, 1, 1, 0, 3'd2, 8'd140, 0);
    smp(8'd120, 1, 0, 0, 3'd2, 8'd140, 0);

    // hysteresis band
    smp(8'd70, 1, 0, 0, 3'd2, 8'd140, 0);
    smp(8'd60, 1, 0, 0, 3'd2, 8'd140, 0);
    smp(8'd80, 1, 0, 0, 3'd2, 8'd140, 0);
    smp(8'd51, 1, 0, 0, 3'd2, 8'd140, 0);
    smp(8'd50, 1, 0, 0, 3'd2, 8'd140, 0);
    smp(8'd50, 0, 0, 1, 3'd2, 8'd120, 0);

    // clear beats the second qualifying sample
    smp(8'd120, 0, 0, 0, 3'd2, 8'd120, 0);
    clear = 1'b1;
    smp(8'd120, 0, 0, 0, 3'd0, 8'd0, 0);
    clear = 1'b0;
    smp(8'd10, 0, 0, 0, 3'd0, 8'd0, 0);

    // illegal thresholds freeze evaluation
    thr_lo = 8'd100;
    idle(1);
    smp(8'd200, 0, 0, 0, 3'd0, 8'd0, 1);
    smp(8'd200, 0, 0, 0, 3'd0, 8'd0, 1);
    thr_lo = 8'd50;
    idle(1);
    smp(8'd200, 0, 0, 0, 3'd0, 8'd0,   0);
    smp(8'd200, 1, 1, 0, 3'd1, 8'd0,   0);
    smp(8'd40,  1, 0, 0, 3'd1, 8'd0,   0);
    smp(8'd40,  0, 0, 1, 3'd1, 8'd200, 0);

    // async reset mid-excursion
    smp(8'd120, 0, 0, 0, 3'd1, 8'd200, 0);
    smp(8'd120, 1, 1, 0, 3'd2, 8'd200, 0);
    smp(8'd150, 1, 0, 0, 3'd2, 8'd200, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // saturation of the 3-bit counter
    smp(8'd10, 0, 0, 0, 3'd0, 8'd0, 0);
    for (int k = 1; k <= 9; k++) begin
      logic [2:0] cp;
      logic [2:0] cn;
      logic [7:0] pk;
      cp = (k - 1 > 7) ? 3'd7 : 3'(k - 1);
      cn = (k > 7) ? 3'd7 : 3'(k);
      pk = (k == 1) ? 8'd0 : 8'd120;
      smp(8'd120, 0, 0, 0, cp, pk,     0);
      smp(8'd120, 1, 1, 0, cn, pk,     0);
      smp(8'd40,  1, 0, 0, cn, pk,     0);
      smp(8'd40,  0, 0, 1, cn, 8'd120, 0);
    end

    idle(3);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
